// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and helpers for the MERA-400 system bus arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, GAP)
//   ow(n)   : width of a requester index for n requesters (at least 1 bit)
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Owner/index width. Two requesters still need one bit.
    function automatic int ow(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational winner selection for the bus arbiter.
// Ports:
//   req   in  N   request vector (zg levels)
//   mask  in  N   hog mask; masked requesters are not eligible
//   ptr   in  OW  round-robin pointer (index of the previous owner)
//   rr    in  1   1 = round-robin, 0 = fixed priority (lowest index wins)
//   win   out OW  winning index (0 when nothing is eligible)
//   valid out 1   some requester is eligible
// ---------------------------------------------------------------------------
module arb_pick
    import bus_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int OW = ow(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [OW-1:0] ptr,
    input  logic          rr,
    output logic [OW-1:0] win,
    output logic          valid
);

    localparam int DW = $clog2(2 * N);

    logic [N-1:0]   elig;
    logic [2*N-1:0] dbl;
    logic [OW-1:0]  rr_win;
    logic [OW-1:0]  fp_win;
    logic [DW-1:0]  pos;

    assign elig  = req & ~mask;
    assign valid = |elig;

    // Two copies of the eligible vector side by side: scanning positions
    // ptr+1 .. ptr+N of the doubled vector visits every requester exactly
    // once, starting just after the pointer, without any modulo wrap logic.
    assign dbl = {elig, elig};

    // Scan from the far end back towards the pointer so the closest hit
    // is the one that sticks.
    always_comb begin
        rr_win = '0;
        pos    = '0;
        for (int k = N; k >= 1; k--) begin
            pos = DW'(ptr) + DW'(k);
            if (dbl[pos]) begin
                if (pos >= DW'(N)) begin
                    rr_win = OW'(pos - DW'(N));
                end else begin
                    rr_win = OW'(pos);
                end
            end
        end
    end

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        fp_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                fp_win = OW'(i);
            end
        end
    end

    assign win = rr ? rr_win : fp_win;

endmodule

// File: rtl/bus_arb.sv
// ---------------------------------------------------------------------------
// bus_arb
// MERA-400 system bus arbiter. Grants the bus to one of N requesters via the
// ZG (request) / ZW (grant) handshake, holds the grant for the whole
// transaction, inserts GAP_TICKS dead cycles between owners and revokes a
// grant held longer than TIMEOUT_TICKS cycles.
// Parameters:
//   N             number of requesters (2..8), index 0 is the CPU
//   RR            1 = round-robin, 0 = fixed priority
//   GAP_TICKS     dead cycles between two owners (1..15)
//   TIMEOUT_TICKS max BUSY cycles per grant (2..65535)
// Ports:
//   clk_sys in  1   system clock
//   clo     in  1   general clear, asynchronous, active-high
//   zg      in  N   bus request per module (level)
//   zw      out N   bus grant per module, registered, one-hot or zero
//   busy    out 1   some zw bit is set
//   owner   out OW  index of the current or last owner
//   bus_to  out 1   one-cycle pulse when the watchdog revokes a grant
//   to_id   out OW  requester revoked by the last timeout
// ---------------------------------------------------------------------------
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter  int N             = 4,
    parameter  int RR            = 1,
    parameter  int GAP_TICKS     = 1,
    parameter  int TIMEOUT_TICKS = 1024,
    localparam int OW            = ow(N)
) (
    input  logic          clk_sys,
    input  logic          clo,
    input  logic [N-1:0]  zg,
    output logic [N-1:0]  zw,
    output logic          busy,
    output logic [OW-1:0] owner,
    output logic          bus_to,
    output logic [OW-1:0] to_id
);

    localparam logic [3:0]  GAP_LOAD = 4'(GAP_TICKS);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_TICKS - 1);
    localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

    state_t        state_reg,  state_next;
    logic [N-1:0]  zw_reg,     zw_next;
    logic [OW-1:0] owner_reg,  owner_next;
    logic [OW-1:0] ptr_reg,    ptr_next;
    logic [N-1:0]  hog_reg,    hog_next;
    logic [3:0]    gap_reg,    gap_next;
    logic [15:0]   wdog_reg,   wdog_next;
    logic [OW-1:0] to_id_reg,  to_id_next;
    logic          bus_to_reg, bus_to_next;

    logic [OW-1:0] pick_win;
    logic          pick_valid;

    arb_pick #(
        .N  (N),
        .OW (OW)
    ) u_pick (
        .req   (zg),
        .mask  (hog_reg),
        .ptr   (ptr_reg),
        .rr    (RR != 0),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // State register. Clear drops the grant immediately, without a clock.
    always_ff @(posedge clk_sys or posedge clo) begin
        if (clo) begin
            state_reg  <= IDLE;
            zw_reg     <= '0;
            owner_reg  <= '0;
            ptr_reg    <= OW'(N - 1);
            hog_reg    <= '0;
            gap_reg    <= '0;
            wdog_reg   <= '0;
            to_id_reg  <= '0;
            bus_to_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            zw_reg     <= zw_next;
            owner_reg  <= owner_next;
            ptr_reg    <= ptr_next;
            hog_reg    <= hog_next;
            gap_reg    <= gap_next;
            wdog_reg   <= wdog_next;
            to_id_reg  <= to_id_next;
            bus_to_reg <= bus_to_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next  = state_reg;
        zw_next     = zw_reg;
        owner_next  = owner_reg;
        ptr_next    = ptr_reg;
        gap_next    = gap_reg;
        wdog_next   = wdog_reg;
        to_id_next  = to_id_reg;
        bus_to_next = 1'b0;
        // A hogging module is forgiven as soon as it lets go of its request.
        hog_next    = hog_reg & zg;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_win;
                    zw_next    = ONE << pick_win;
                    wdog_next  = '0;
                    state_next = BUSY;
                end
            end

            BUSY: begin
                // Release is checked first so that a release coinciding
                // with watchdog expiry is a normal release.
                if (!zg[owner_reg]) begin
                    zw_next    = '0;
                    ptr_next   = owner_reg;
                    gap_next   = GAP_LOAD;
                    state_next = GAP;
                end else if (wdog_reg == WD_LAST) begin
                    zw_next             = '0;
                    bus_to_next         = 1'b1;
                    to_id_next          = owner_reg;
                    hog_next[owner_reg] = 1'b1;
                    ptr_next            = owner_reg;
                    gap_next            = GAP_LOAD;
                    state_next          = GAP;
                end else begin
                    wdog_next = wdog_reg + 16'd1;
                end
            end

            GAP: begin
                // The counter holds the number of dead cycles still to run,
                // including the current one; at 1 this is the last.
                if (gap_reg <= 4'd1) begin
                    if (pick_valid) begin
                        owner_next = pick_win;
                        zw_next    = ONE << pick_win;
                        wdog_next  = '0;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end

            default: begin
                zw_next    = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign zw     = zw_reg;
    assign busy   = |zw_reg;
    assign owner  = owner_reg;
    assign bus_to = bus_to_reg;
    assign to_id  = to_id_reg;

endmodule

// File: tb/tb_bus_arb.sv
`timescale 1ns/1ps
module tb_bus_arb;

    typedef struct {
        logic [3:0] zw;
        logic       bus_to;
        logic [1:0] to_id;
        logic [1:0] owner;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       clo = 1'b1;
    logic [3:0] zg  = 4'b0000;

    logic [3:0] zw0, zw1;
    logic       busy0, busy1, bto0, bto1;
    logic [1:0] own0, own1, tid0, tid1;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, one slot per DUT (0: round-robin, 1: fixed).
    int         m_owner[2];   // -1 when the bus is free
    int         m_gstart[2];  // edge at which the current grant was given
    int         m_free[2];    // earliest edge at which a new grant may occur
    int         m_last[2];    // previous owner, for round-robin order
    logic [3:0] m_hog[2];
    logic [1:0] m_oout[2];
    logic [1:0] m_toid[2];
    logic [3:0] prev_zw[2];

    always #5 clk = ~clk;

    bus_arb #(.N(4), .RR(1), .GAP_TICKS(1), .TIMEOUT_TICKS(8)) u_rr (
        .clk_sys (clk), .clo (clo), .zg (zg), .zw (zw0), .busy (busy0),
        .owner (own0), .bus_to (bto0), .to_id (tid0)
    );

    bus_arb #(.N(4), .RR(0), .GAP_TICKS(3), .TIMEOUT_TICKS(12)) u_fp (
        .clk_sys (clk), .clo (clo), .zg (zg), .zw (zw1), .busy (busy1),
        .owner (own1), .bus_to (bto1), .to_id (tid1)
    );

    function automatic int p_rr(input int d);
        return (d == 0) ? 1 : 0;
    endfunction
    function automatic int p_gap(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic int p_to(input int d);
        return (d == 0) ? 8 : 12;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d]  = -1;
            m_gstart[d] = 0;
            m_free[d]   = 0;
            m_last[d]   = 3;
            m_hog[d]    = 4'b0000;
            m_oout[d]   = 2'd0;
            m_toid[d]   = 2'd0;
            prev_zw[d]  = 4'b0000;
        end
    endtask

    function automatic int pick(input int d, input logic [3:0] elig);
        int idx;
        if (p_rr(d) != 0) begin
            for (int j = 1; j <= 4; j++) begin
                idx = (m_last[d] + j) % 4;
                if (elig[idx]) return idx;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (elig[i]) return i;
            end
        end
        return -1;
    endfunction

    // One clock edge of the arbiter, in terms of who owns the bus, since
    // when, and from when the bus may be handed out again.
    task automatic model_step(input int d, input logic [3:0] z, output exp_t x);
        logic [3:0] elig;
        int o;
        int w;
        x.bus_to = 1'b0;
        elig     = z & ~m_hog[d];
        m_hog[d] = m_hog[d] & z;
        o        = m_owner[d];
        if (o >= 0) begin
            if (!z[o]) begin
                m_last[d]  = o;
                m_owner[d] = -1;
                m_free[d]  = ecount + p_gap(d);
            end else if (ecount - m_gstart[d] == p_to(d)) begin
                m_last[d]   = o;
                m_owner[d]  = -1;
                m_free[d]   = ecount + p_gap(d);
                m_hog[d][o] = 1'b1;
                m_toid[d]   = 2'(o);
                x.bus_to    = 1'b1;
            end
        end else if (ecount >= m_free[d]) begin
            w = pick(d, elig);
            if (w >= 0) begin
                m_owner[d]  = w;
                m_gstart[d] = ecount;
                m_oout[d]   = 2'(w);
            end
        end
        x.zw    = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
        x.to_id = m_toid[d];
        x.owner = m_oout[d];
        x.cyc   = 0;
    endtask

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    // Advance one edge; the model sees the same zg the DUTs sample.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        ecount++;
        if (!clo) begin
            model_step(0, zg, x);
            x.cyc = ecount;
            q0.push_back(x);
            model_step(1, zg, x);
            x.cyc = ecount;
            q1.push_back(x);
        end
        #2;
    endtask

    // Requesters hold zg=base; the owner chosen by model d drops its
    // request for one edge, three cycles after its grant.
    task automatic agent_phase(input int d, input logic [3:0] base, input int edges);
        zg = base;
        repeat (edges) begin
            tick();
            zg = base;
            if (m_owner[d] >= 0 && (ecount - m_gstart[d]) == 2) zg[m_owner[d]] = 1'b0;
        end
    endtask

    task automatic cmp(input int d, input exp_t x, input logic [3:0] zw_a, input logic busy_a,
                       input logic bto_a, input logic [1:0] tid_a, input logic [1:0] own_a);
        string p;
        p = (d == 0) ? "rr" : "fp";
        chk({p, "_zw"},     x.cyc, 8'(zw_a),   8'(x.zw));
        chk({p, "_busy"},   x.cyc, 8'(busy_a), 8'(|x.zw));
        chk({p, "_bus_to"}, x.cyc, 8'(bto_a),  8'(x.bus_to));
        chk({p, "_to_id"},  x.cyc, 8'(tid_a),  8'(x.to_id));
        chk({p, "_owner"},  x.cyc, 8'(own_a),  8'(x.owner));
        if (x.zw != 4'b0000 && x.zw != prev_zw[d])
            $display("[TB] edge %0d %s grant zw=%b", x.cyc, p, x.zw);
        if (x.bus_to)
            $display("[TB] edge %0d %s timeout to_id=%0d", x.cyc, p, x.to_id);
        prev_zw[d] = x.zw;
    endtask

    // Monitor: compare whatever the DUTs present against the queued
    // expectations, half a cycle after each edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                x = q0.pop_front();
                cmp(0, x, zw0, busy0, bto0, tid0, own0);
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                cmp(1, x, zw1, busy1, bto1, tid1, own1);
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("rst_zw0",    0, 8'(zw0),   8'h0);
        chk("rst_zw1",    0, 8'(zw1),   8'h0);
        chk("rst_busy0",  0, 8'(busy0), 8'h0);
        chk("rst_owner0", 0, 8'(own0),  8'h0);
        chk("rst_bus_to", 0, 8'(bto0),  8'h0);
        chk("rst_to_id",  0, 8'(tid1),  8'h0);
        tick();
        tick();
        clo = 1'b0;

        // Single requester.
        zg = 4'b0100; repeat (7) tick();
        zg = 4'b0000; repeat (6) tick();

        // Round-robin order with drop/re-raise, then fixed-priority style.
        agent_phase(0, 4'b1111, 30);
        zg = 4'b0000; repeat (6) tick();
        agent_phase(1, 4'b1110, 24);
        agent_phase(1, 4'b1111, 16);
        zg = 4'b0000; repeat (6) tick();

        // Stuck requester: timeout, no re-grant until it drops for a cycle.
        zg = 4'b1000; repeat (20) tick();
        zg = 4'b0000; tick();
        zg = 4'b1000; repeat (16) tick();
        zg = 4'b0000; repeat (6) tick();

        // Release exactly when the fast watchdog expires.
        zg = 4'b1000; repeat (8) tick();
        zg = 4'b0000; repeat (6) tick();
        zg = 4'b1000; repeat (5) tick();
        zg = 4'b0000; repeat (6) tick();

        // Clear mid-transaction.
        zg = 4'b0010; repeat (3) tick();
        chk("pre_clo_zw0", ecount, 8'(zw0), 8'h02);
        clo = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("clo_async_zw0",  ecount, 8'(zw0),   8'h0);
        chk("clo_async_zw1",  ecount, 8'(zw1),   8'h0);
        chk("clo_async_busy", ecount, 8'(busy1), 8'h0);
        model_reset();
        zg = 4'b1010;
        tick();
        clo = 1'b0;
        repeat (6) tick();
        zg = 4'b0000; repeat (6) tick();

        // Randomised request levels.
        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(5, 0) == 0) zg[i] = ~zg[i];
            end
            tick();
        end
        zg = 4'b0000; repeat (4) tick();

        #5;
        chk("q0_drained", ecount, 8'(q0.size()), 8'h0);
        chk("q1_drained", ecount, 8'(q1.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
